fft_frame_ctrl: RTL and testbench

- Sequences one complete FFT transform on the FFT core's three AXI-Stream channels: config, data input and data output.
- On a start request it captures the scaling schedule and direction, then issues exactly one config beat.
- It then gates exactly one frame of NFFT input samples into the core, generating tlast itself.
- It monitors the core's output frame and raises a done pulse. It sits between the register interface and the FFT core.

---
 rtl/fft_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fft_frame_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: runs one FFT transform on the core's three AXI-Stream channels.
//   On an accepted start it captures the scaling schedule and direction, issues a
//   single config beat, gates exactly NFFT input samples into the core (driving
//   tlast itself), watches the core's output frame and pulses done.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   start                  one-cycle run request, honoured only when idle
//   scale_sch, forward     transform settings, captured on accepted start
//   busy, done             status: not idle / one-cycle completion pulse
//   err_len                sticky output-frame length error, cleared by start
//   cfg_*                  config channel to the core, tdata = {scale, forward}
//   s_*                    sample source stream
//   fft_in_*               core data input
//   fft_out_*              core data output
//   m_*                    result stream (pure pass-through of fft_out_*)
module fft_frame_ctrl #(
  parameter int unsigned LOG2_NFFT = 8,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [7:0]        scale_sch,
  input  logic              forward,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              cfg_tvalid,
  input  logic              cfg_tready,
  output logic [8:0]        cfg_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  output logic              fft_in_tvalid,
  input  logic              fft_in_tready,
  output logic [DATA_W-1:0] fft_in_tdata,
  output logic              fft_in_tlast,
  input  logic              fft_out_tvalid,
  output logic              fft_out_tready,
  input  logic [DATA_W-1:0] fft_out_tdata,
  input  logic              fft_out_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast
);

  typedef enum logic [2:0] {
    StIdle,
    StConfig,
    StLoad,
    StDrain,
    StDone
  } state_e;

  // Last index of a frame (NFFT-1) is all ones at counter width.
  localparam logic [LOG2_NFFT-1:0] CntLast = '1;
  localparam logic [LOG2_NFFT-1:0] CntOne  = {{(LOG2_NFFT-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [7:0]           scale_q;
  logic                 fwd_q;
  logic [LOG2_NFFT-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2_NFFT-1:0] out_cnt_q, out_cnt_d;
  logic                 err_len_q, err_len_d;
  logic                 seen_q, seen_d;
  logic                 out_last_idx;

  // Output path is a plain pass-through so the result frame may overlap LOAD.
  assign m_tvalid       = fft_out_tvalid;
  assign fft_out_tready = m_tready;
  assign m_tdata        = fft_out_tdata;
  assign m_tlast        = fft_out_tlast;

  assign fft_in_tdata = s_tdata;
  assign cfg_tdata    = {scale_q, fwd_q};
  assign err_len      = err_len_q;
  assign out_last_idx = (out_cnt_q == CntLast);

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    out_cnt_d     = out_cnt_q;
    err_len_d     = err_len_q;
    seen_d        = seen_q;
    busy          = (state_q != StIdle);
    done          = 1'b0;
    cfg_tvalid    = 1'b0;
    s_tready      = 1'b0;
    fft_in_tvalid = 1'b0;
    fft_in_tlast  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StConfig;
          err_len_d = 1'b0;
          seen_d    = 1'b0;
          // Drop any stale count left by a frame that ended on an early tlast.
          out_cnt_d = '0;
        end
      end
      StConfig: begin
        cfg_tvalid = 1'b1;
        if (cfg_tready) begin
          in_cnt_d = '0;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        fft_in_tvalid = s_tvalid;
        s_tready      = fft_in_tready;
        fft_in_tlast  = (in_cnt_q == CntLast);
        if (s_tvalid && fft_in_tready) begin
          in_cnt_d = in_cnt_q + CntOne;
          if (in_cnt_q == CntLast) state_d = StDrain;
        end
      end
      StDrain: begin
        if (seen_q) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A frame ends on either the count reaching NFFT-1 or an explicit tlast;
    // disagreement between the two is a length error.
    if (busy && fft_out_tvalid && m_tready) begin
      if (out_last_idx || fft_out_tlast) begin
        if (out_last_idx != fft_out_tlast) err_len_d = 1'b1;
        seen_d    = 1'b1;
        out_cnt_d = '0;
      end else begin
        out_cnt_d = out_cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      scale_q   <= 8'h00;
      fwd_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_len_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      err_len_q <= err_len_d;
      seen_q    <= seen_d;
      if (state_q == StIdle && start) begin
        scale_q <= scale_sch;
        fwd_q   <= forward;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb_fft_frame_ctrl: self-checking bench for fft_frame_ctrl with NFFT = 8.
// A transaction-level model tracks what the controller owes (config beat,
// samples, output frame) and is compared against the DUT every cycle.
module tb_fft_frame_ctrl;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam logic [31:0] SrcBase = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start, forward, busy, done, err_len;
  logic [7:0]    scale_sch;
  logic          cfg_tvalid, cfg_tready;
  logic [8:0]    cfg_tdata;
  logic          s_tvalid, s_tready;
  logic [DW-1:0] s_tdata;
  logic          fft_in_tvalid, fft_in_tready, fft_in_tlast;
  logic [DW-1:0] fft_in_tdata;
  logic          fft_out_tvalid, fft_out_tready, fft_out_tlast;
  logic [DW-1:0] fft_out_tdata;
  logic          m_tvalid, m_tready, m_tlast;
  logic [DW-1:0] m_tdata;

  always #5 clk = ~clk;

  fft_frame_ctrl #(.LOG2_NFFT(3), .DATA_W(DW)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .start          (start),
    .scale_sch      (scale_sch),
    .forward        (forward),
    .busy           (busy),
    .done           (done),
    .err_len        (err_len),
    .cfg_tvalid     (cfg_tvalid),
    .cfg_tready     (cfg_tready),
    .cfg_tdata      (cfg_tdata),
    .s_tvalid       (s_tvalid),
    .s_tready       (s_tready),
    .s_tdata        (s_tdata),
    .fft_in_tvalid  (fft_in_tvalid),
    .fft_in_tready  (fft_in_tready),
    .fft_in_tdata   (fft_in_tdata),
    .fft_in_tlast   (fft_in_tlast),
    .fft_out_tvalid (fft_out_tvalid),
    .fft_out_tready (fft_out_tready),
    .fft_out_tdata  (fft_out_tdata),
    .fft_out_tlast  (fft_out_tlast),
    .m_tvalid       (m_tvalid),
    .m_tready       (m_tready),
    .m_tdata        (m_tdata),
    .m_tlast        (m_tlast)
  );

  int checks = 0;
  int errors = 0;
  bit rnd = 1'b0;
  int out_len = N;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + per-cycle compare ----------------
  bit         m_active, m_cfg_owed, m_out_seen, m_done, m_err;
  int         m_n_in, m_n_out;
  logic [8:0] m_word;
  int         cfg_valid_cycles = 0;
  int         done_cnt = 0;

  initial begin
    bit loading, busy_pre, end_cnt;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        m_active = 0; m_cfg_owed = 0; m_out_seen = 0; m_done = 0; m_err = 0;
        m_n_in = 0; m_n_out = 0; m_word = 9'h000;
      end
      loading = m_active && !m_cfg_owed && (m_n_in < N);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      chk("err_len", err_len, m_err);
      chk("cfg_tvalid", cfg_tvalid, m_active && m_cfg_owed);
      chk("cfg_tdata", cfg_tdata, m_word);
      chk("s_tready", s_tready, loading ? fft_in_tready : 1'b0);
      chk("fft_in_tvalid", fft_in_tvalid, loading ? s_tvalid : 1'b0);
      if (loading) begin
        chk("fft_in_tdata", fft_in_tdata, s_tdata);
        chk("fft_in_tlast", fft_in_tlast, m_n_in == N - 1);
      end
      chk("m_tvalid", m_tvalid, fft_out_tvalid);
      chk("m_tdata", m_tdata, fft_out_tdata);
      chk("m_tlast", m_tlast, fft_out_tlast);
      chk("fft_out_tready", fft_out_tready, m_tready);
      if (cfg_tvalid === 1'b1) cfg_valid_cycles++;
      if (done === 1'b1) done_cnt++;

      if (resetn) begin
        busy_pre = m_active;
        if (m_done) begin
          m_done = 0; m_active = 0;
        end else if (!m_active) begin
          if (start) begin
            m_active = 1; m_cfg_owed = 1; m_n_in = 0; m_n_out = 0;
            m_out_seen = 0; m_err = 0; m_word = {scale_sch, forward};
          end
        end else if (m_cfg_owed) begin
          if (cfg_tready) m_cfg_owed = 0;
        end else if (m_n_in < N) begin
          if (s_tvalid && fft_in_tready) m_n_in++;
        end else if (m_out_seen) begin
          m_done = 1;
        end
        if (busy_pre && fft_out_tvalid && m_tready) begin
          m_n_out++;
          end_cnt = (m_n_out == N);
          if (end_cnt || fft_out_tlast) begin
            if (end_cnt != fft_out_tlast) m_err = 1;
            m_out_seen = 1;
            m_n_out = 0;
          end
        end
      end
    end
  end

  // ---------------- sample source ----------------
  int src_idx = 0;
  initial begin
    bit hs;
    s_tvalid = 1'b0;
    s_tdata  = SrcBase;
    forever begin
      @(negedge clk);
      hs = s_tvalid && s_tready;
      @(posedge clk); #1;
      if (hs) src_idx++;
      s_tdata  = SrcBase + 32'(src_idx);
      s_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- FFT core stand-in + result sink ----------------
  logic [DW-1:0] fbuf [N];
  int in_idx = 0, out_idx = 0, core_exp = 0, frames_in = 0;
  bit have = 1'b0;
  initial begin
    bit ihs, itl, ohs, rst_seen;
    logic [DW-1:0] idat;
    for (int i = 0; i < N; i++) fbuf[i] = '0;
    fft_in_tready = 1'b0; fft_out_tvalid = 1'b0; fft_out_tdata = '0;
    fft_out_tlast = 1'b0; m_tready = 1'b0;
    forever begin
      @(negedge clk);
      ihs = fft_in_tvalid && fft_in_tready;
      itl = fft_in_tlast;
      idat = fft_in_tdata;
      ohs = fft_out_tvalid && fft_out_tready;
      rst_seen = !resetn;
      @(posedge clk); #1;
      if (rst_seen) begin
        in_idx = 0; out_idx = 0; have = 0;
      end else begin
        if (ihs) begin
          chk("core_in_order", idat, SrcBase + 32'(core_exp));
          core_exp++;
          fbuf[in_idx] = idat;
          in_idx++;
          if (itl) begin
            chk("core_frame_len", in_idx, N);
            frames_in++;
          end
          if (in_idx == N) begin have = 1; in_idx = 0; end
        end
        if (ohs) begin
          out_idx++;
          if (out_idx == out_len) begin have = 0; out_idx = 0; end
        end
      end
      fft_in_tready  = !have && (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      fft_out_tvalid = have;
      fft_out_tdata  = ~fbuf[out_idx];
      fft_out_tlast  = have && (out_idx == out_len - 1);
      m_tready       = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // ---------------- directed tests ----------------
  task automatic sync();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] sc, input logic fw);
    sync();
    start = 1'b1; scale_sch = sc; forward = fw;
    sync();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit got = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1;
    end
    chk(name, got, 1'b1);
    sync();
  endtask

  initial begin
    int d0, c0, f0, n;
    start = 1'b0; scale_sch = 8'h00; forward = 1'b0; cfg_tready = 1'b1;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cfg_tdata", cfg_tdata, 9'h000);
    chk("rst_err_len", err_len, 1'b0);

    // Nominal frame
    d0 = done_cnt; c0 = cfg_valid_cycles; f0 = frames_in;
    do_start(8'hA5, 1'b1);
    @(negedge clk);
    chk("t1_cfg_tvalid", cfg_tvalid, 1'b1);
    chk("t1_cfg_tdata", cfg_tdata, 9'h14B);
    wait_done("t1_done_seen");
    chk("t1_busy_low", busy, 1'b0);
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_cfg_cycles", cfg_valid_cycles - c0, 1);
    chk("t1_frames", frames_in - f0, 1);

    // Config back-pressure
    c0 = cfg_valid_cycles;
    cfg_tready = 1'b0;
    do_start(8'h5A, 1'b0);
    repeat (4) sync();
    chk("t2_cfg_tdata", cfg_tdata, 9'h0B4);
    chk("t2_s_tready", s_tready, 1'b0);
    sync();
    cfg_tready = 1'b1;
    wait_done("t2_done_seen");
    chk("t2_cfg_cycles", cfg_valid_cycles - c0, 6);

    // Random stalls, three back-to-back frames
    rnd = 1'b1;
    d0 = done_cnt; f0 = frames_in;
    for (int i = 0; i < 3; i++) begin
      do_start(8'h30 + 8'(i), 1'b1);
      wait_done("t3_done_seen");
    end
    rnd = 1'b0;
    chk("t3_done_cnt", done_cnt - d0, 3);
    chk("t3_frames", frames_in - f0, 3);
    chk("t3_err_len", err_len, 1'b0);

    // Early output tlast
    out_len = 5;
    do_start(8'h11, 1'b1);
    wait_done("t4_done_seen");
    repeat (3) sync();
    chk("t4_err_sticky", err_len, 1'b1);
    out_len = N;
    do_start(8'h22, 1'b0);
    @(negedge clk);
    chk("t4_err_cleared", err_len, 1'b0);
    wait_done("t4b_done_seen");

    // Start while busy is ignored
    c0 = cfg_valid_cycles;
    do_start(8'h3C, 1'b0);
    n = 0;
    for (int k = 0; k < 200 && n == 0; k++) begin
      @(negedge clk);
      if (s_tready === 1'b1) n = 1;
    end
    chk("t5_reached_load", n, 1);
    do_start(8'h00, 1'b1);
    @(negedge clk);
    chk("t5_cfg_kept", cfg_tdata, 9'h078);
    chk("t5_busy", busy, 1'b1);
    wait_done("t5_done_seen");
    chk("t5_cfg_cycles", cfg_valid_cycles - c0, 1);

    // Reset mid-LOAD
    do_start(8'h44, 1'b1);
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      @(negedge clk);
      if (fft_in_tvalid && fft_in_tready) n++;
    end
    chk("t6_four_beats", n, 4);
    d0 = done_cnt;
    @(posedge clk); #1 resetn = 1'b0;
    #1;
    chk("t6_busy", busy, 1'b0);
    chk("t6_cfg_tvalid", cfg_tvalid, 1'b0);
    chk("t6_s_tready", s_tready, 1'b0);
    chk("t6_cfg_tdata", cfg_tdata, 9'h000);
    repeat (3) sync();
    resetn = 1'b1;
    repeat (3) sync();
    chk("t6_no_done", done_cnt - d0, 0);
    f0 = frames_in;
    do_start(8'h55, 1'b1);
    wait_done("t6_done_seen");
    chk("t6_done_cnt", done_cnt - d0, 1);
    chk("t6_frames", frames_in - f0, 1);

    repeat (3) sync();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
